// File: rtl/br_pkg.sv
// Shared types for the branch resolver: the predictor-update packet,
// the shadow-pipeline slot and a saturating-increment helper.
package br_pkg;

    localparam int INDEX_W_DEF = 6;
    localparam int TAG_W_DEF   = 30 - INDEX_W_DEF;

    // One predictor-update entry as it travels through the update FIFO.
    typedef struct packed {
        logic [INDEX_W_DEF-1:0] index;
        logic [TAG_W_DEF-1:0]   tag;
        logic [31:0]            target;
        logic                   taken;
    } upd_pkt_t;

    // Prediction made at fetch, carried alongside the instruction.
    typedef struct packed {
        logic        pred_taken;
        logic [31:0] pred_pc;
    } shadow_slot_t;

    localparam shadow_slot_t SLOT_EMPTY = '{pred_taken: 1'b0, pred_pc: 32'd0};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/br_upd_fifo.sv
// Show-ahead FIFO for predictor-update packets. The head entry is presented
// with valid/ready; a push into a full FIFO without a simultaneous pop is
// dropped and latches a sticky overflow flag. DEPTH must be a power of two
// (>= 2) so the pointers wrap by natural overflow.
module br_upd_fifo
    import br_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  upd_pkt_t push_data,
    input  logic     pop_ready,
    output logic     valid,
    output upd_pkt_t head,
    output logic     full,
    output logic     empty,
    output logic     overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    upd_pkt_t         store_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             overflow_reg;

    logic pop_en;
    logic push_en;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (PTR_W + 1)'(DEPTH));
    assign valid    = ~empty;
    assign head     = store_reg[rd_ptr_reg];
    assign overflow = overflow_reg;

    // A pop needs a valid head; a push into a full FIFO only fits if the head leaves.
    assign pop_en  = pop_ready & ~empty;
    assign push_en = push & (~full | pop_en);

    // Payload storage: written on accepted pushes only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_en) begin
            store_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers, occupancy and sticky overflow; reset discards in-flight entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (push && full && !pop_en) begin
                overflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: carries fetch-time predictions through a shadow
// ID/EX/MEM pipeline, compares them with the actual outcome in MEM,
// redirects and flushes on a mispredict with zero latency, and queues a
// predictor update for every resolved branch.
// Optional statistics counters are enabled by defining BR_RESOLVER_STATS_EN.
module branch_resolver
    import br_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int INDEX_W    = INDEX_W_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           pc_if_i,
    input  logic                  pred_taken_if_i,
    input  logic [31:0]           pred_pc_if_i,
    input  logic                  stall_i,
    input  logic                  branch_mem_i,
    input  logic                  br_sel_mem_i,
    input  logic [31:0]           alu_data_mem_i,
    input  logic [31:0]           pc_four_mem_i,
    output logic                  redirect_o,
    output logic [31:0]           redirect_pc_o,
    output logic                  flush_o,
    output logic                  upd_valid_o,
    input  logic                  upd_ready_i,
    output logic [INDEX_W-1:0]    upd_index_o,
    output logic [30-INDEX_W-1:0] upd_tag_o,
    output logic [31:0]           upd_target_o,
    output logic                  upd_taken_o,
    output logic                  overflow_o,
    output logic [31:0]           branch_cnt_o,
    output logic [31:0]           mispred_cnt_o
);

    shadow_slot_t id_reg;
    shadow_slot_t ex_reg;
    shadow_slot_t mem_reg;

    logic        resolve;
    logic        mispredict;
    logic [31:0] mem_pc;
    upd_pkt_t    push_pkt;
    upd_pkt_t    head_pkt;
    logic        fifo_full;
    logic        fifo_empty;

    // The fetch PC itself is not needed: MEM supplies PC+4 for the same instruction.
    logic unused_bits;
    assign unused_bits = ^{pc_if_i, mem_pc[1:0], fifo_full, fifo_empty};

    assign resolve = branch_mem_i & ~stall_i;
    assign mem_pc  = pc_four_mem_i - 32'd4;

    // Taken: wrong if predicted not-taken or predicted a different target.
    // Not taken: wrong only if it was predicted taken.
    always_comb begin
        mispredict = 1'b0;
        if (resolve) begin
            if (br_sel_mem_i) begin
                mispredict = ~mem_reg.pred_taken | (mem_reg.pred_pc != alu_data_mem_i);
            end else begin
                mispredict = mem_reg.pred_taken;
            end
        end
    end

    assign redirect_o    = mispredict;
    assign flush_o       = mispredict;
    assign redirect_pc_o = mispredict ? (br_sel_mem_i ? alu_data_mem_i : pc_four_mem_i) : 32'd0;

    // Shadow pipeline: advance when not stalled; on a mispredict the younger
    // (flushed) slots lose their taken prediction and ID takes a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_reg  <= SLOT_EMPTY;
            ex_reg  <= SLOT_EMPTY;
            mem_reg <= SLOT_EMPTY;
        end else if (!stall_i) begin
            if (mispredict) begin
                id_reg  <= SLOT_EMPTY;
                ex_reg  <= '{pred_taken: 1'b0, pred_pc: id_reg.pred_pc};
                mem_reg <= '{pred_taken: 1'b0, pred_pc: ex_reg.pred_pc};
            end else begin
                id_reg  <= '{pred_taken: pred_taken_if_i, pred_pc: pred_pc_if_i};
                ex_reg  <= id_reg;
                mem_reg <= ex_reg;
            end
        end
    end

    // Index and tag together always span PC[31:2]; the FIFO only carries
    // them, so the 30-bit pair is filled as one vector and split by INDEX_W.
    always_comb begin
        push_pkt = '0;
        {push_pkt.index, push_pkt.tag} = {mem_pc[INDEX_W+1:2], mem_pc[31:INDEX_W+2]};
        push_pkt.target = alu_data_mem_i;
        push_pkt.taken  = br_sel_mem_i;
    end

    br_upd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_upd_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push     (resolve),
        .push_data(push_pkt),
        .pop_ready(upd_ready_i),
        .valid    (upd_valid_o),
        .head     (head_pkt),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (overflow_o)
    );

    assign {upd_index_o, upd_tag_o} = {head_pkt.index, head_pkt.tag};
    assign upd_target_o = head_pkt.target;
    assign upd_taken_o  = head_pkt.taken;

`ifdef BR_RESOLVER_STATS_EN
    logic [31:0] branch_cnt_reg;
    logic [31:0] mispred_cnt_reg;

    // Saturating counts of resolved branches and mispredicts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_reg  <= 32'd0;
            mispred_cnt_reg <= 32'd0;
        end else begin
            if (resolve) begin
                branch_cnt_reg <= sat_inc(branch_cnt_reg);
            end
            if (mispredict) begin
                mispred_cnt_reg <= sat_inc(mispred_cnt_reg);
            end
        end
    end

    assign branch_cnt_o  = branch_cnt_reg;
    assign mispred_cnt_o = mispred_cnt_reg;
`else
    assign branch_cnt_o  = 32'd0;
    assign mispred_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed testbench for branch_resolver (FIFO_DEPTH=2, INDEX_W=6).
// Counter expectations follow BR_RESOLVER_STATS_EN when it is defined.
module tb_branch_resolver;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_if_i;
    logic        pred_taken_if_i;
    logic [31:0] pred_pc_if_i;
    logic        stall_i;
    logic        branch_mem_i;
    logic        br_sel_mem_i;
    logic [31:0] alu_data_mem_i;
    logic [31:0] pc_four_mem_i;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        upd_valid_o;
    logic        upd_ready_i;
    logic [5:0]  upd_index_o;
    logic [23:0] upd_tag_o;
    logic [31:0] upd_target_o;
    logic        upd_taken_o;
    logic        overflow_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    int exp_br   = 0;
    int exp_mis  = 0;

    branch_resolver #(
        .FIFO_DEPTH(2),
        .INDEX_W   (6)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pc_if_i        (pc_if_i),
        .pred_taken_if_i(pred_taken_if_i),
        .pred_pc_if_i   (pred_pc_if_i),
        .stall_i        (stall_i),
        .branch_mem_i   (branch_mem_i),
        .br_sel_mem_i   (br_sel_mem_i),
        .alu_data_mem_i (alu_data_mem_i),
        .pc_four_mem_i  (pc_four_mem_i),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
        .flush_o        (flush_o),
        .upd_valid_o    (upd_valid_o),
        .upd_ready_i    (upd_ready_i),
        .upd_index_o    (upd_index_o),
        .upd_tag_o      (upd_tag_o),
        .upd_target_o   (upd_target_o),
        .upd_taken_o    (upd_taken_o),
        .overflow_o     (overflow_o),
        .branch_cnt_o   (branch_cnt_o),
        .mispred_cnt_o  (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Move to the falling edge, where outputs are sampled.
    task automatic settle();
        #4;
    endtask

    task automatic check_counters(input string tag);
`ifdef BR_RESOLVER_STATS_EN
        check({tag, "_branch_cnt"}, branch_cnt_o, 32'(exp_br));
        check({tag, "_mispred_cnt"}, mispred_cnt_o, 32'(exp_mis));
`else
        check({tag, "_branch_cnt"}, branch_cnt_o, 32'd0);
        check({tag, "_mispred_cnt"}, mispred_cnt_o, 32'd0);
`endif
    endtask

    task automatic clear_mem();
        branch_mem_i   = 1'b0;
        br_sel_mem_i   = 1'b0;
        alu_data_mem_i = 32'd0;
        pc_four_mem_i  = 32'd0;
    endtask

    // Fetch one prediction, let it reach MEM, resolve it, then check the
    // update that appears the next cycle. Requires upd_ready_i=1.
    task automatic run_branch(input string name, input logic pt, input logic [31:0] ppc,
                              input logic sel, input logic [31:0] alu, input logic [31:0] pc4,
                              input logic exp_redir, input logic [31:0] exp_rpc,
                              input logic [5:0] exp_idx, input logic [23:0] exp_tag);
        pred_taken_if_i = pt;
        pred_pc_if_i    = ppc;
        pc_if_i         = pc4 - 32'd4;
        tick();
        pred_taken_if_i = 1'b0;
        pred_pc_if_i    = 32'd0;
        pc_if_i         = 32'd0;
        tick();
        tick();
        branch_mem_i   = 1'b1;
        br_sel_mem_i   = sel;
        alu_data_mem_i = alu;
        pc_four_mem_i  = pc4;
        settle();
        check({name, "_redirect"}, 32'(redirect_o), 32'(exp_redir));
        check({name, "_flush"}, 32'(flush_o), 32'(exp_redir));
        check({name, "_redirect_pc"}, redirect_pc_o, exp_rpc);
        check({name, "_valid_before"}, 32'(upd_valid_o), 32'd0);
        exp_br++;
        if (exp_redir) exp_mis++;
        tick();
        clear_mem();
        settle();
        check({name, "_upd_valid"}, 32'(upd_valid_o), 32'd1);
        check({name, "_upd_index"}, 32'(upd_index_o), 32'(exp_idx));
        check({name, "_upd_tag"}, 32'(upd_tag_o), 32'(exp_tag));
        check({name, "_upd_target"}, upd_target_o, alu);
        check({name, "_upd_taken"}, 32'(upd_taken_o), 32'(sel));
        check({name, "_redirect_idle"}, 32'(redirect_o), 32'd0);
        check_counters(name);
        $display("branch %s: pc=0x%08h redirect=%0b rpc=0x%08h idx=0x%02h tag=0x%06h",
                 name, pc4 - 32'd4, exp_redir, exp_rpc, exp_idx, exp_tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        pc_if_i = 32'd0;
        pred_taken_if_i = 1'b0;
        pred_pc_if_i = 32'd0;
        stall_i = 1'b0;
        upd_ready_i = 1'b1;
        clear_mem();

        // Reset state
        tick();
        tick();
        rst_i = 1'b0;
        settle();
        check("rst_upd_valid", 32'(upd_valid_o), 32'd0);
        check("rst_redirect", 32'(redirect_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_redirect_pc", redirect_pc_o, 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check_counters("rst");

        // Prediction scenarios
        run_branch("mispred_taken", 1'b0, 32'h0, 1'b1, 32'h200, 32'h104,
                   1'b1, 32'h200, 6'h00, 24'h000001);
        tick();
        run_branch("correct_taken", 1'b1, 32'h300, 1'b1, 32'h300, 32'h3C8,
                   1'b0, 32'h0, 6'h31, 24'h000003);
        tick();
        run_branch("wrong_target", 1'b1, 32'h300, 1'b1, 32'h304, 32'h3C8,
                   1'b1, 32'h304, 6'h31, 24'h000003);
        tick();
        run_branch("mispred_nt", 1'b1, 32'h500, 1'b0, 32'h500, 32'h108,
                   1'b1, 32'h108, 6'h01, 24'h000001);
        tick();
        run_branch("correct_nt", 1'b0, 32'h0, 1'b0, 32'h40, 32'h1000,
                   1'b0, 32'h0, 6'h3F, 24'h00000F);
        tick();
        run_branch("pc_wrap", 1'b0, 32'h0, 1'b1, 32'h80, 32'h0,
                   1'b1, 32'h80, 6'h3F, 24'hFFFFFF);
        tick();

        // Backpressure: three resolves into a 2-deep FIFO
        upd_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            branch_mem_i   = 1'b1;
            br_sel_mem_i   = 1'b0;
            alu_data_mem_i = 32'hA0 + 32'(4 * i);
            pc_four_mem_i  = 32'h10C + 32'(4 * i);
            tick();
            exp_br++;
        end
        clear_mem();
        settle();
        check("bp_valid", 32'(upd_valid_o), 32'd1);
        check("bp_head_index", 32'(upd_index_o), 32'h02);
        check("bp_head_target", upd_target_o, 32'hA0);
        check("bp_overflow", 32'(overflow_o), 32'd1);
        check_counters("bp");
        tick();
        settle();
        check("bp_head_stable", upd_target_o, 32'hA0);
        $display("backpressure: 3 pushes, head=0x%08h overflow=%0b", upd_target_o, overflow_o);

        // Push and pop together while full, then drain
        upd_ready_i    = 1'b1;
        branch_mem_i   = 1'b1;
        alu_data_mem_i = 32'hAC;
        pc_four_mem_i  = 32'h118;
        settle();
        check("full_pp_head", upd_target_o, 32'hA0);
        tick();
        exp_br++;
        clear_mem();
        settle();
        check("drain1_index", 32'(upd_index_o), 32'h03);
        check("drain1_target", upd_target_o, 32'hA4);
        tick();
        settle();
        check("drain2_valid", 32'(upd_valid_o), 32'd1);
        check("drain2_index", 32'(upd_index_o), 32'h05);
        check("drain2_target", upd_target_o, 32'hAC);
        tick();
        settle();
        check("drain_empty", 32'(upd_valid_o), 32'd0);
        check("overflow_sticky", 32'(overflow_o), 32'd1);
        check_counters("drain");
        $display("drain: push+pop while full, entries popped in order");

        // Stall holds a pending branch for two cycles
        stall_i        = 1'b1;
        branch_mem_i   = 1'b1;
        br_sel_mem_i   = 1'b1;
        alu_data_mem_i = 32'h600;
        pc_four_mem_i  = 32'h204;
        settle();
        check("stall1_redirect", 32'(redirect_o), 32'd0);
        check("stall1_flush", 32'(flush_o), 32'd0);
        tick();
        settle();
        check("stall2_redirect", 32'(redirect_o), 32'd0);
        check("stall2_valid", 32'(upd_valid_o), 32'd0);
        tick();
        stall_i = 1'b0;
        settle();
        check("unstall_redirect", 32'(redirect_o), 32'd1);
        check("unstall_redirect_pc", redirect_pc_o, 32'h600);
        check("stall_no_push", 32'(upd_valid_o), 32'd0);
        exp_br++;
        exp_mis++;
        tick();
        clear_mem();
        settle();
        check("unstall_valid", 32'(upd_valid_o), 32'd1);
        check("unstall_target", upd_target_o, 32'h600);
        check("unstall_index", 32'(upd_index_o), 32'h00);
        check("unstall_tag", 32'(upd_tag_o), 32'h02);
        check_counters("unstall");
        tick();
        settle();
        check("unstall_single_push", 32'(upd_valid_o), 32'd0);
        $display("stall: branch held 2 cycles, one push on release");

        // Reset while FIFO is full and a mispredict is on the inputs
        upd_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            branch_mem_i   = 1'b1;
            br_sel_mem_i   = 1'b0;
            alu_data_mem_i = 32'hB0 + 32'(4 * i);
            pc_four_mem_i  = 32'h10C;
            tick();
            exp_br++;
        end
        rst_i          = 1'b1;
        branch_mem_i   = 1'b1;
        br_sel_mem_i   = 1'b1;
        alu_data_mem_i = 32'h777;
        pc_four_mem_i  = 32'h304;
        settle();
        check("prerst_overflow", 32'(overflow_o), 32'd1);
        check("prerst_redirect", 32'(redirect_o), 32'd1);
        tick();
        rst_i = 1'b0;
        clear_mem();
        exp_br  = 0;
        exp_mis = 0;
        settle();
        check("postrst_valid", 32'(upd_valid_o), 32'd0);
        check("postrst_overflow", 32'(overflow_o), 32'd0);
        check("postrst_redirect", 32'(redirect_o), 32'd0);
        check_counters("postrst");
        $display("reset: FIFO full + mispredict discarded");

        upd_ready_i = 1'b1;
        run_branch("after_reset", 1'b1, 32'h900, 1'b1, 32'h900, 32'h124,
                   1'b0, 32'h0, 6'h08, 24'h000001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of update-FIFO entries (power of two, at least 2).
REQ-002 SHALL have parameter INDEX_W, default 6, meaning the predictor index width taken from PC[INDEX_W+1:2]; tag width is 30-INDEX_W.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, with all state updated on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port pc_if_i, input, 32 bits: the PC of the instruction in IF.
REQ-006 SHALL have port pred_taken_if_i, input, 1 bit: the predictor hit/taken indication for the IF instruction.
REQ-007 SHALL have port pred_pc_if_i, input, 32 bits: the predicted target for the IF instruction.
REQ-008 SHALL have port stall_i, input, 1 bit: when high, the shadow pipeline holds and nothing resolves.
REQ-009 SHALL have ports branch_mem_i (input, 1 bit), br_sel_mem_i (input, 1 bit), alu_data_mem_i (input, 32 bits) and pc_four_mem_i (input, 32 bits), meaning MEM-stage branch valid, actual taken, actual target and PC+4.
REQ-010 SHALL have ports redirect_o (output, 1 bit) and redirect_pc_o (output, 32 bits), meaning a fetch redirect on mispredict.
REQ-011 SHALL have port flush_o, output, 1 bit: kill the younger IF, ID and EX instructions.
REQ-012 SHALL have ports upd_valid_o (output, 1 bit), upd_ready_i (input, 1 bit), upd_index_o (output, INDEX_W bits), upd_tag_o (output, 30-INDEX_W bits), upd_target_o (output, 32 bits) and upd_taken_o (output, 1 bit), meaning the predictor-update stream.
REQ-013 SHALL have ports overflow_o (output, 1 bit), branch_cnt_o (output, 32 bits) and mispred_cnt_o (output, 32 bits).

Function
REQ-014 SHALL carry {pred_taken, pred_pc} through shadow slots ID, EX and MEM, advancing one slot per cycle while stall_i=0.
REQ-015 SHALL resolve only in a cycle where branch_mem_i=1 and stall_i=0, so each branch resolves exactly once.
REQ-016 SHALL compute the MEM PC as pc_four_mem_i-4, modulo 2^32.
REQ-017 SHALL flag a mispredict when br_sel_mem_i=1 and (MEM slot pred_taken=0 or MEM slot pred_pc!=alu_data_mem_i).
REQ-018 SHALL also flag a mispredict when br_sel_mem_i=0 and MEM slot pred_taken=1.
REQ-019 SHALL, on mispredict, drive redirect_o=flush_o=1 combinationally in the resolve cycle (zero latency), with redirect_pc_o = br_sel_mem_i ? alu_data_mem_i : pc_four_mem_i.
REQ-020 SHALL drive redirect_pc_o=0 whenever redirect_o=0.
REQ-021 SHALL, on the edge that ends a mispredict cycle, clear pred_taken in the ID and EX slots and load the ID slot with a not-taken entry.
REQ-022 SHALL, on every resolve, push {index, tag, target=alu_data_mem_i, taken=br_sel_mem_i} into the update FIFO.
REQ-023 SHALL use valid/ready on the update stream: an entry pops on the edge where upd_valid_o=1 and upd_ready_i=1, and the head stays stable while upd_ready_i=0.
REQ-024 SHALL make pushed data visible on upd_*_o one cycle after the push.
REQ-025 SHALL accept a push and pop in the same cycle while full, leaving the count unchanged.
REQ-026 SHALL accept a simultaneous push and pop while empty.
REQ-027 SHALL drop the new entry on a push while full without a pop, and set overflow_o sticky until reset.
REQ-028 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.

Reset
REQ-029 SHALL clear, on a rst_i-high edge, all shadow slots (not-taken, pred_pc=0), the FIFO pointers and count, overflow_o and both counters.
REQ-030 SHALL have upd_valid_o=0, redirect_o=0 and flush_o=0 after reset.
REQ-031 SHALL give reset priority over a push, pop or stall in the same cycle, and SHALL discard in-flight FIFO entries.

Configuration
REQ-032 SHALL, with macro BR_RESOLVER_STATS_EN defined, implement branch_cnt_o (+1 per resolve) and mispred_cnt_o (+1 per mispredict), both saturating at 0xFFFFFFFF.
REQ-033 SHALL, with BR_RESOLVER_STATS_EN undefined, tie both counter ports to 0 with no counter flops.

Structure
REQ-034 SHALL place INDEX_W_DEF, the upd_pkt_t packed struct {index, tag, target, taken} and the shadow-slot struct in package br_pkg.
REQ-035 SHALL implement the FIFO as sub-module br_upd_fifo, with push/pop/full/empty/overflow handling and the payload typed as upd_pkt_t.

Verification
REQ-036 SHALL cover this scenario: IF pc 0x100 with pred_taken=0; 3 cycles later branch_mem_i=1, br_sel_mem_i=1, alu_data_mem_i=0x200, pc_four_mem_i=0x104 -> redirect_o=1, redirect_pc_o=0x200, flush_o=1, next cycle upd_index_o=0x00, upd_tag_o=0x000001, upd_target_o=0x200, upd_taken_o=1.
REQ-037 SHALL cover this scenario: predicted taken to 0x300 and actual taken to 0x300 -> no redirect, and one update with taken=1.
REQ-038 SHALL cover this scenario: predicted taken and actually not taken with pc_four_mem_i=0x108 -> redirect_pc_o=0x108.
REQ-039 SHALL cover this scenario: upd_ready_i=0 with 3 resolves and FIFO_DEPTH=2 -> FIFO holds the first two, overflow_o=1; then ready=1 -> two pops in order, upd_valid_o then 0.
REQ-040 SHALL cover this scenario: stall_i=1 for 2 cycles with branch_mem_i=1 -> no resolve and no push; on release exactly one push, and with BR_RESOLVER_STATS_EN defined branch_cnt_o increments by 1.
REQ-041 SHALL cover this scenario: rst_i pulsed while FIFO full and a mispredict is present -> next cycle upd_valid_o=0, overflow_o=0, counters 0.
